ads1675_acq_ctrl: RTL and testbench
===================================

// Module: ads1675_acq_ctrl
// PURPOSE
//  Acquisition sequencer between the ADS1675 LVDS deserializer and the AXI4-Lite sample FIFO.
//  - Sequences ADC power-up, settling, first-sample discard and a counted or continuous run.
//  - Gates deserialized 24-bit samples into FIFO writes.
//  - Raises the threshold IRQ consumed by the PS drain loop and flags FIFO overflow.
//  - Configured from the axi4l_fifo control registers.
// PARAMETERS
//  SETTLE_CYCLES  1024  aclk cycles pown held high before start asserts
//  DISCARD        4     samples dropped after start (ADC digital filter settling)
//  LVL_W          12    width of FIFO level / threshold (FIFO depth 2**LVL_W-1)
// PORTS
//  aclk           in   1      system clock; all logic on rising edge
//  areset         in   1      asynchronous, active-high reset
//  cfg_enable     in   1      level; 1 = acquire, 0 = abort to IDLE
//  cfg_nsamples   in   32     samples to capture; 0 = continuous
//  cfg_threshold  in   LVL_W  IRQ threshold (words); 0 disables IRQ
//  irq_ack        in   1      1-cycle pulse, clears irq
//  smp_valid      in   1      1-cycle strobe, new sample on smp_data
//  smp_data       in   24     two's-complement ADC sample
//  fifo_level     in   LVL_W  current FIFO occupancy
//  fifo_full      in   1      FIFO cannot accept a write this cycle
//  fifo_wr_en     out  1      FIFO write strobe
//  fifo_wr_data   out  32     FIFO write word
//  pown           out  1      ADC power-on (1 = powered)
//  start          out  1      ADC conversion start
//  busy           out  1      state != IDLE
//  done           out  1      sticky; counted run complete
//  overflow       out  1      sticky; sample lost to fifo_full
//  irq            out  1      level interrupt to PS
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; counters 0; irq armed.
//  - States and transitions:
//      IDLE->POWER on cfg_enable=1 (clears done, overflow, sample count).
//      POWER: pown=1; after SETTLE_CYCLES cycles ->SYNC.
//      SYNC: pown=1, start=1; drops DISCARD smp_valid strobes, then ->RUN.
//      RUN: each smp_valid gives, registered, fifo_wr_en=1 next cycle (latency 1).
//      RUN->DONE when count==cfg_nsamples (nsamples!=0).
//      DONE: start=0, pown=1, done=1; stays until cfg_enable=0.
//  - cfg_enable=0 in any state ->IDLE next cycle: pown=start=0; done/overflow hold.
//  - Write data: fifo_wr_data = {{8{smp_data[23]}},smp_data} (sign extension).
//  - fifo_full at smp_valid in RUN:
//      no write; overflow<=1 (sticky until next IDLE->POWER).
//      Sample still counted toward cfg_nsamples.
//  - Sample count: 32-bit, saturates at 2^32-1 in continuous mode; never wraps.
//  - Last counted sample is written in the same cycle DONE is entered; no extra writes after.
//  - IRQ:
//      irq<=1 when armed && cfg_threshold!=0 && fifo_level>=cfg_threshold.
//      irq_ack: irq<=0, armed<=0.
//      Re-arm when fifo_level<cfg_threshold.
//      irq_ack and set condition in same cycle: ack wins; no re-set until re-armed.
//      irq independent of state (drains in DONE/IDLE still interrupt).
//  - smp_valid outside SYNC/RUN is ignored.
//  - areset mid-run: immediate return to reset values; in-flight write suppressed.
// CONFIGURATION
//  - Macro ACQ_SEQTAG_EN:
//      defined: fifo_wr_data[31:24] = 8-bit write sequence tag, +1 per written word.
//               Tag resets to 0 on IDLE->POWER; wraps 255->0.
//               Dropped (overflow) samples do not advance the tag, so PS can detect gaps.
//      undefined: [31:24] = sign extension as above; no tag counter synthesized.
// TESTING
//  - Bring-up, SETTLE_CYCLES=16, DISCARD=4:
//      cfg_enable=1 -> pown=1 at cycle 1, start=1 at cycle 17.
//      First 4 strobes give no write; 5th gives fifo_wr_en one cycle later.
//  - Counted run, cfg_nsamples=10, smp_data=24'h800001:
//      exactly 10 writes of 32'hFF800001 -> done=1, busy=1, start=0.
//  - Overflow: hold fifo_full=1 for strobes 3..4 of cfg_nsamples=6:
//      4 writes, overflow=1, done after 6th strobe.
//      With ACQ_SEQTAG_EN, tags 0,1,2,3.
//  - IRQ, cfg_threshold=512:
//      fifo_level 511->512 -> irq=1; irq_ack -> irq=0.
//      Level stays 600 -> irq stays 0; drops to 0 then back to 512 -> irq=1.
//      ack and level=512 in same cycle -> irq=0.
//  - Abort: cfg_enable=0 mid-RUN -> next cycle IDLE, pown=start=fifo_wr_en=0.
//      overflow keeps its value; re-enable clears it.
//  - areset pulse during SYNC -> all outputs 0 asynchronously; restart reproduces bring-up timing.

Source files
------------

// File: rtl/ads1675_acq_ctrl.sv
// ADS1675 acquisition sequencer: power-up, settle, discard, counted/continuous capture into the FIFO, threshold IRQ.
// Optional ACQ_SEQTAG_EN puts an 8-bit write sequence tag in fifo_wr_data[31:24].
module ads1675_acq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned DISCARD       = 4,
  parameter int unsigned LVL_W         = 12
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             cfg_enable,
  input  logic [31:0]      cfg_nsamples,
  input  logic [LVL_W-1:0] cfg_threshold,
  input  logic             irq_ack,
  input  logic             smp_valid,
  input  logic [23:0]      smp_data,
  input  logic [LVL_W-1:0] fifo_level,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [31:0]      fifo_wr_data,
  output logic             pown,
  output logic             start,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic             irq
);

  // state | meaning
  // IDLE  | ADC off, waiting for cfg_enable
  // POWER | pown high, settle timer running
  // SYNC  | start high, dropping filter-settling samples
  // RUN   | samples gated into the FIFO
  // DONE  | counted run complete, ADC powered, start low

  localparam int unsigned TMR_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned DSC_W = (DISCARD > 0) ? $clog2(DISCARD + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [DSC_W-1:0] DSC_LOAD = DSC_W'(DISCARD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POWER,
    S_SYNC,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic [TMR_W-1:0] tmr_q;
  logic [DSC_W-1:0] dsc_q;
  logic [31:0]      cnt_q;
  logic [31:0]      cnt_d;
  logic             pown_q;
  logic             start_q;
  logic             busy_q;
  logic             done_q;
  logic             ovf_q;
  logic             wr_en_q;
  logic [31:0]      wr_data_q;
  logic [31:0]      wr_word;
  logic             irq_q;
  logic             armed_q;

  logic enter_power;
  logic run_smp;
  logic wr_take;
  logic last_smp;
  logic thr_hit;
  logic below_thr;

  assign enter_power = (state_q == S_IDLE) && cfg_enable;
  assign run_smp     = (state_q == S_RUN) && cfg_enable && smp_valid;
  assign wr_take     = run_smp && !fifo_full;

  // Saturating count so continuous mode never wraps back into a counted match.
  assign cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
  assign last_smp = (cfg_nsamples != 32'd0) && (cnt_d >= cfg_nsamples);

`ifdef ACQ_SEQTAG_EN
  logic [7:0] tag_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tag_q <= 8'd0;
    end else if (enter_power) begin
      tag_q <= 8'd0;
    end else if (wr_take) begin
      tag_q <= tag_q + 8'd1;
    end
  end

  assign wr_word = {tag_q, smp_data};
`else
  assign wr_word = {{8{smp_data[23]}}, smp_data};
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      dsc_q     <= '0;
      cnt_q     <= '0;
      pown_q    <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (!cfg_enable) begin
        state_q <= S_IDLE;
        pown_q  <= 1'b0;
        start_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            state_q <= S_POWER;
            tmr_q   <= TMR_LOAD;
            cnt_q   <= '0;
            pown_q  <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
          end
          S_POWER: begin
            if (tmr_q == '0) begin
              state_q <= (DISCARD == 0) ? S_RUN : S_SYNC;
              dsc_q   <= DSC_LOAD;
              start_q <= 1'b1;
            end else begin
              tmr_q <= tmr_q - TMR_W'(1);
            end
          end
          S_SYNC: begin
            if (smp_valid) begin
              dsc_q <= dsc_q - DSC_W'(1);
              if (dsc_q == DSC_W'(1)) begin
                state_q <= S_RUN;
              end
            end
          end
          S_RUN: begin
            if (run_smp) begin
              cnt_q <= cnt_d;
              if (wr_take) begin
                wr_en_q   <= 1'b1;
                wr_data_q <= wr_word;
              end else begin
                ovf_q <= 1'b1;
              end
              if (last_smp) begin
                state_q <= S_DONE;
                start_q <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
          S_DONE: begin
            start_q <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            pown_q  <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign thr_hit   = (cfg_threshold != '0) && (fifo_level >= cfg_threshold);
  assign below_thr = fifo_level < cfg_threshold;

  // Ack beats a simultaneous set; re-arming only happens once the level drops below threshold.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      irq_q   <= 1'b0;
      armed_q <= 1'b1;
    end else if (irq_ack) begin
      irq_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      if (armed_q && thr_hit) begin
        irq_q <= 1'b1;
      end
      if (below_thr) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign pown         = pown_q;
  assign start        = start_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overflow     = ovf_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_ads1675_acq_ctrl.sv
// Self-checking bench for ads1675_acq_ctrl: randomized runs against a transaction-level model, plus IRQ model.
module tb_ads1675_acq_ctrl;

  localparam int SETTLE = 16;
  localparam int DISC   = 4;
  localparam int LVL_W  = 12;

  logic             aclk = 1'b0;
  logic             areset;
  logic             cfg_enable;
  logic [31:0]      cfg_nsamples;
  logic [LVL_W-1:0] cfg_threshold;
  logic             irq_ack;
  logic             smp_valid;
  logic [23:0]      smp_data;
  logic [LVL_W-1:0] fifo_level;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [31:0]      fifo_wr_data;
  logic             pown;
  logic             start;
  logic             busy;
  logic             done;
  logic             overflow;
  logic             irq;

  ads1675_acq_ctrl #(
    .SETTLE_CYCLES(SETTLE),
    .DISCARD      (DISC),
    .LVL_W        (LVL_W)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .cfg_enable   (cfg_enable),
    .cfg_nsamples (cfg_nsamples),
    .cfg_threshold(cfg_threshold),
    .irq_ack      (irq_ack),
    .smp_valid    (smp_valid),
    .smp_data     (smp_data),
    .fifo_level   (fifo_level),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .pown         (pown),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow),
    .irq          (irq)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] wr_q[$];
  logic [31:0] exp_q[$];
  int          exp_tag;
  bit          m_irq;
  bit          m_armed;

  always @(negedge aclk) begin
    if (fifo_wr_en === 1'b1) wr_q.push_back(fifo_wr_data);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] model_word(input logic [23:0] d);
    logic [31:0] w;
    w = 32'($signed(d));
`ifdef ACQ_SEQTAG_EN
    w[31:24] = 8'(exp_tag % 256);
`endif
    return w;
  endfunction

  task automatic strobe(input logic [23:0] d, input logic full, input int gap);
    smp_valid = 1'b1;
    smp_data  = d;
    fifo_full = full;
    tick();
    smp_valid = 1'b0;
    fifo_full = 1'($urandom_range(0, 1));
    repeat (gap) tick();
  endtask

  task automatic bringup(input string nm);
    cfg_enable = 1'b1;
    tick();
    chk({nm, "_pown1"}, 32'(pown), 32'd1);
    chk({nm, "_start1"}, 32'(start), 32'd0);
    chk({nm, "_busy1"}, 32'(busy), 32'd1);
    chk({nm, "_done_clr"}, 32'(done), 32'd0);
    chk({nm, "_ovf_clr"}, 32'(overflow), 32'd0);
    repeat (SETTLE - 1) tick();
    chk({nm, "_start16"}, 32'(start), 32'd0);
    tick();
    chk({nm, "_start17"}, 32'(start), 32'd1);
    exp_tag = 0;
  endtask

  task automatic do_run(input string nm, input int ns, input int f_lo, input int f_hi,
                        input bit fixed, input logic [23:0] fdata);
    logic [23:0] d;
    logic        f;
    bit          exp_ovf;
    exp_ovf      = 1'b0;
    cfg_nsamples = 32'(ns);
    wr_q.delete();
    exp_q.delete();
    bringup(nm);
    for (int i = 0; i < DISC; i++)
      strobe(24'($urandom), 1'($urandom_range(0, 1)), $urandom_range(1, 3));
    chk({nm, "_discard"}, 32'(wr_q.size()), 32'd0);
    chk({nm, "_ovf_sync"}, 32'(overflow), 32'd0);
    for (int i = 1; i <= ns; i++) begin
      d = fixed ? fdata : 24'($urandom);
      f = (i >= f_lo) && (i <= f_hi);
      if (f) exp_ovf = 1'b1;
      else begin
        exp_q.push_back(model_word(d));
        exp_tag++;
      end
      if (i == ns) begin
        chk({nm, "_done_early"}, 32'(done), 32'd0);
        strobe(d, f, 0);
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_last_wr"}, 32'(fifo_wr_en), 32'(!f));
        chk({nm, "_busy"}, 32'(busy), 32'd1);
        chk({nm, "_start0"}, 32'(start), 32'd0);
        chk({nm, "_pown"}, 32'(pown), 32'd1);
        chk({nm, "_ovf"}, 32'(overflow), 32'(exp_ovf));
      end else begin
        strobe(d, f, $urandom_range(0, 3));
      end
    end
    strobe(24'($urandom), 1'b0, 1);
    strobe(24'($urandom), 1'b0, 1);
    tick();
    chk({nm, "_nwr"}, 32'(wr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      chk($sformatf("%s_w%0d", nm, i), wr_q[i], exp_q[i]);
    chk({nm, "_done_hold"}, 32'(done), 32'd1);
    cfg_enable = 1'b0;
    tick();
    chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
    chk({nm, "_idle_pown"}, 32'(pown), 32'd0);
    chk({nm, "_idle_done"}, 32'(done), 32'd1);
    chk({nm, "_idle_ovf"}, 32'(overflow), 32'(exp_ovf));
    fifo_full = 1'b0;
    tick();
  endtask

  task automatic irq_step(input int lvl, input int thr, input bit ack, input string tag, input int want);
    fifo_level    = LVL_W'(lvl);
    cfg_threshold = LVL_W'(thr);
    irq_ack       = ack;
    if (ack) begin
      m_irq   = 1'b0;
      m_armed = 1'b0;
    end else begin
      if (m_armed && thr != 0 && lvl >= thr) m_irq = 1'b1;
      if (lvl < thr) m_armed = 1'b1;
    end
    tick();
    irq_ack = 1'b0;
    chk(tag, 32'(irq), (want < 0) ? 32'(m_irq) : 32'(want));
  endtask

  int irq_lv[15]  = '{511, 512, 512, 512, 600, 600, 600, 0, 512, 600, 0, 512, 512, 0, 512};
  int irq_ak[15]  = '{0,   0,   0,   1,   0,   0,   0,   0, 0,   1,   0, 1,   0,   0, 0};
  int irq_exp[15] = '{0,   1,   1,   0,   0,   0,   0,   0, 1,   0,   0, 0,   0,   0, 1};

  initial begin
    logic [23:0] d;
    int          thr;
    int          lvl;
    int          ns;
    int          flo;

    areset        = 1'b1;
    cfg_enable    = 1'b0;
    cfg_nsamples  = '0;
    cfg_threshold = '0;
    irq_ack       = 1'b0;
    smp_valid     = 1'b0;
    smp_data      = '0;
    fifo_level    = '0;
    fifo_full     = 1'b0;
    exp_tag       = 0;
    m_irq         = 1'b0;
    m_armed       = 1'b1;

    repeat (3) tick();
    chk("rst_outs", 32'({pown, start, busy, done, overflow, irq, fifo_wr_en}), 32'd0);
    chk("rst_data", fifo_wr_data, 32'd0);
    areset = 1'b0;
    tick();
    chk("rst_idle", 32'({pown, start, busy}), 32'd0);

    for (int i = 0; i < 15; i++)
      irq_step(irq_lv[i], 512, irq_ak[i] != 0, $sformatf("irq_dir%0d", i), irq_exp[i]);
    thr = 512;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0:       thr = 0;
          1:       thr = 1;
          2:       thr = 512;
          default: thr = 4095;
        endcase
      end
      lvl = (thr == 0) ? int'($urandom_range(0, 4095)) : thr + int'($urandom_range(0, 6)) - 3;
      if (lvl < 0) lvl = 0;
      if (lvl > 4095) lvl = 4095;
      irq_step(lvl, thr, $urandom_range(0, 7) == 0, "irq_rand", -1);
    end
    irq_step(0, 512, 1'b1, "irq_end_ack", 0);
    irq_step(0, 512, 1'b0, "irq_end_rearm", 0);
    cfg_threshold = '0;

    do_run("cnt10", 10, 99, 99, 1'b1, 24'h800001);
`ifdef ACQ_SEQTAG_EN
    if (wr_q.size() > 0) chk("cnt10_w0_const", wr_q[0], 32'h00800001);
`else
    if (wr_q.size() > 0) chk("cnt10_w0_const", wr_q[0], 32'hFF800001);
`endif

    do_run("ovf6", 6, 3, 4, 1'b0, 24'h0);
    chk("ovf6_nwr_const", 32'(wr_q.size()), 32'd4);

    for (int r = 0; r < 4; r++) begin
      ns  = $urandom_range(3, 20);
      flo = $urandom_range(1, ns + 2);
      do_run($sformatf("rnd%0d", r), ns, flo, flo + int'($urandom_range(0, 3)), 1'b0, 24'h0);
    end

    cfg_nsamples = 32'd0;
    bringup("abort");
    for (int i = 0; i < DISC; i++) begin
      strobe(24'($urandom), 1'($urandom_range(0, 1)), 0);
      chk("abort_disc_wr", 32'(fifo_wr_en), 32'd0);
    end
    d = 24'h7ABCDE;
    strobe(d, 1'b0, 0);
    chk("abort_wr5", 32'(fifo_wr_en), 32'd1);
    chk("abort_wr5_data", fifo_wr_data, model_word(d));
    exp_tag++;
    tick();
    chk("abort_wr_pulse", 32'(fifo_wr_en), 32'd0);
    strobe(24'($urandom), 1'b1, 0);
    chk("abort_full_nowr", 32'(fifo_wr_en), 32'd0);
    chk("abort_ovf_set", 32'(overflow), 32'd1);
    smp_valid  = 1'b1;
    fifo_full  = 1'b0;
    cfg_enable = 1'b0;
    tick();
    smp_valid = 1'b0;
    chk("abort_outs", 32'({pown, start, busy, fifo_wr_en}), 32'd0);
    chk("abort_ovf_hold", 32'(overflow), 32'd1);
    tick();
    chk("abort_ovf_hold2", 32'(overflow), 32'd1);
    cfg_enable = 1'b1;
    tick();
    chk("reen_ovf_clr", 32'(overflow), 32'd0);
    chk("reen_pown", 32'(pown), 32'd1);
    cfg_enable = 1'b0;
    repeat (2) tick();

    bringup("rst2");
    strobe(24'($urandom), 1'b0, 1);
    #2;
    areset     = 1'b1;
    cfg_enable = 1'b0;
    #1;
    chk("arst_outs", 32'({pown, start, busy, done, overflow, irq, fifo_wr_en}), 32'd0);
    chk("arst_data", fifo_wr_data, 32'd0);
    tick();
    areset = 1'b0;
    tick();
    bringup("restart");
    for (int i = 0; i < DISC; i++) begin
      strobe(24'($urandom), 1'b0, 1);
      chk("restart_disc_wr", 32'(fifo_wr_en), 32'd0);
    end
    strobe(24'h000123, 1'b0, 0);
    chk("restart_wr5", 32'(fifo_wr_en), 32'd1);
    chk("restart_wr5_data", fifo_wr_data, model_word(24'h000123));
    cfg_enable = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
